// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous instruction ROM.
// Owns the PC, issues ROM reads under a two-word credit limit, captures the
// returning words into a 2-entry FIFO and presents {pc, instruction} to decode.
module fetch_unit #(
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ADDRESS_WIDTH = 12,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_WIDTH-1:0]    inst_data,
  output logic [ADDRESS_WIDTH-1:0] inst_pc
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  // Fetch state
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     inflight;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;

  // FIFO state: slot0 is always the head, slot1 the second entry
  logic [1:0] count;
  entry_t     slot0, slot1;
  entry_t     slot0_next, slot1_next;
  entry_t     incoming;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occupancy;
  logic [1:0] count_after_pop;

  // A redirect overrides the sequential PC in the same cycle it is presented.
  assign rom_addr = redirect_valid ? redirect_pc : pc;

  assign pop       = inst_valid & inst_ready;
  assign occupancy = count + {1'b0, inflight};

  // Credit rule: only issue when the word can be guaranteed a FIFO slot two
  // cycles from now. Occupancy is always >= pop, so the subtraction cannot wrap.
  // A redirect always issues because it also flushes everything already held.
  assign issue = redirect_valid | ((occupancy - {1'b0, pop}) < 2'd2);

  // The ROM word that returns this cycle belongs to last cycle's issue,
  // unless a redirect makes it stale.
  assign push     = inflight & ~redirect_valid;
  assign incoming = '{pc: inflight_pc, data: rom_data};

  assign count_after_pop = count - {1'b0, pop};

  // PC and in-flight tracking: remember what address the ROM is reading.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= rom_addr;
      pc          <= rom_addr + ADDRESS_WIDTH'(1);
    end else begin
      inflight    <= 1'b0;
    end
  end

  // FIFO occupancy: a redirect clears it; otherwise push and pop net out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 2'd0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage next-state: pop shifts slot1 forward, push fills the first free slot.
  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    if (pop) begin
      slot0_next = slot1;
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        slot0_next = incoming;
      end else begin
        slot1_next = incoming;
      end
    end
  end

  // FIFO storage registers.
  // NOTE: the data slots are not reset; count alone decides validity and the
  // outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    slot0 <= slot0_next;
    slot1 <= slot1_next;
  end

  assign inst_valid = (count != 2'd0);
  assign inst_pc    = inst_valid ? slot0.pc   : '0;
  assign inst_data  = inst_valid ? slot0.data : '0;

endmodule
